// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter with a registered one-hot grant for eight requesters.
// A grant is held until the owner releases it or the hold watchdog revokes it.
module rr_grant_arbiter8 #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16,
   parameter int CW       = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         release_pulse,  // owner-done strobe; "release" is a reserved word
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout
);

   localparam int PW = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          grant_valid_q, grant_valid_d;
   logic          timeout_q, timeout_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;

   logic [PW-1:0] scan_idx;
   logic [PW-1:0] win_idx;
   logic          win_found;
   logic [PW-1:0] next_ptr;

   // Scan from ptr upward with wrap; the first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int i = 0; i < N; i++) begin
         scan_idx = PW'((int'(ptr_q) + i) % N);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign next_ptr = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      hold_cnt_d    = hold_cnt_q;

      unique case (state_q)
         IDLE: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            if (win_found) begin
               state_d       = GRANT;
               grant_d       = N'(1) << win_idx;
               grant_valid_d = 1'b1;
               owner_d       = win_idx;
               hold_cnt_d    = '0;
            end
         end
         GRANT: begin
            // Release takes precedence over the watchdog when both land together.
            if (release_pulse || hold_cnt_q == CW'(MAX_HOLD - 1)) begin
               state_d       = IDLE;
               grant_d       = '0;
               grant_valid_d = 1'b0;
               ptr_d         = next_ptr;
               timeout_d     = !release_pulse;
            end else begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: synchronous reset sampled on the clock edge; state uses non-blocking updates only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         ptr_q         <= '0;
         owner_q       <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Scoreboard bench for rr_grant_arbiter8: each step queues the outputs
// expected after the next edge, then pops and compares them.
module tb_rr_grant_arbiter8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       release_pulse;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   typedef struct {
      logic       rn;
      logic [7:0] rq;
      logic       rel;
      logic [7:0] eg;
      logic       et;
   } stim_t;

   typedef struct {
      logic [7:0] grant;
      logic       timeout;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   rr_grant_arbiter8 #(.N(8), .MAX_HOLD(16), .CW(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .release_pulse(release_pulse),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .timeout      (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Per-cycle invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         n_cmp += 3;
         if (!$onehot0(grant)) begin
            n_err++;
            $display("FAIL inv_onehot0: grant=%h", grant);
         end
         if (grant_valid !== (grant != 8'h00)) begin
            n_err++;
            $display("FAIL inv_valid: grant_valid=%b grant=%h", grant_valid, grant);
         end
         if (timeout && grant != 8'h00) begin
            n_err++;
            $display("FAIL inv_timeout_idle: timeout=%b grant=%h", timeout, grant);
         end
      end
   end

   function automatic stim_t st(logic rn, logic [7:0] rq, logic rel, logic [7:0] eg, logic et);
      stim_t s;
      s.rn = rn; s.rq = rq; s.rel = rel; s.eg = eg; s.et = et;
      return s;
   endfunction

   // Drives one cycle of inputs, queues the expected outputs, then advances past the edge.
   task automatic drive_step(input stim_t s);
      exp_t e;
      rst_n         = s.rn;
      req           = s.rq;
      release_pulse = s.rel;
      e.grant       = s.eg;
      e.timeout     = s.et;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e;
      s.push_back(st(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0));
      s.push_back(st(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h00, 1'b0, 8'h00, 1'b0));
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL reset grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL reset valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL reset timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   task automatic test_basic();
      stim_t s[$];
      exp_t  e;
      s.push_back(st(1'b1, 8'h24, 1'b0, 8'h04, 1'b0));
      s.push_back(st(1'b1, 8'h24, 1'b1, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h24, 1'b0, 8'h20, 1'b0));
      s.push_back(st(1'b1, 8'h24, 1'b1, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h00, 1'b1, 8'h00, 1'b0));  // release while idle is ignored
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL basic grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL basic valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL basic timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   task automatic test_fairness();
      stim_t      s[$];
      exp_t       e;
      logic [7:0] one;
      one = 8'h01;
      s.push_back(st(1'b1, 8'h80, 1'b0, 8'h80, 1'b0));  // move ptr back to 0
      s.push_back(st(1'b1, 8'h80, 1'b1, 8'h00, 1'b0));
      for (int k = 0; k < 18; k++)
         s.push_back(st(1'b1, 8'hFF, 1'b1, (k % 2 == 0) ? (one << ((k / 2) % 8)) : 8'h00, 1'b0));
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL fair grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL fair valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL fair timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   task automatic test_timeout();
      stim_t s[$];
      exp_t  e;
      for (int k = 0; k < 16; k++) s.push_back(st(1'b1, 8'h01, 1'b0, 8'h01, 1'b0));
      s.push_back(st(1'b1, 8'h01, 1'b0, 8'h00, 1'b1));
      s.push_back(st(1'b1, 8'h00, 1'b0, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h03, 1'b0, 8'h02, 1'b0));  // ptr advanced to 1
      s.push_back(st(1'b1, 8'h03, 1'b1, 8'h00, 1'b0));
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL tmo grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL tmo valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL tmo timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   task automatic test_coincide_and_hold();
      stim_t s[$];
      exp_t  e;
      for (int k = 0; k < 16; k++) s.push_back(st(1'b1, 8'h04, 1'b0, 8'h04, 1'b0));
      s.push_back(st(1'b1, 8'h04, 1'b1, 8'h00, 1'b0));  // 16th hold cycle with release
      s.push_back(st(1'b1, 8'h08, 1'b0, 8'h08, 1'b0));
      for (int k = 0; k < 5; k++) s.push_back(st(1'b1, 8'h00, 1'b0, 8'h08, 1'b0));
      s.push_back(st(1'b1, 8'h01, 1'b0, 8'h08, 1'b0));
      s.push_back(st(1'b1, 8'h00, 1'b1, 8'h00, 1'b0));
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL coin grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL coin valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL coin timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   task automatic test_reset_mid_grant();
      stim_t s[$];
      exp_t  e;
      for (int k = 0; k < 8; k++) s.push_back(st(1'b1, 8'h10, 1'b0, 8'h10, 1'b0));
      s.push_back(st(1'b0, 8'h10, 1'b0, 8'h00, 1'b0));  // hold_cnt is 7 here
      s.push_back(st(1'b1, 8'h11, 1'b0, 8'h01, 1'b0));  // ptr back at 0
      s.push_back(st(1'b1, 8'h11, 1'b1, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h80, 1'b0, 8'h80, 1'b0));
      s.push_back(st(1'b1, 8'h80, 1'b1, 8'h00, 1'b0));
      s.push_back(st(1'b1, 8'h00, 1'b0, 8'h00, 1'b0));
      foreach (s[i]) begin
         drive_step(s[i]);
         e = exp_q.pop_front();
         n_cmp += 3;
         if (grant !== e.grant) begin n_err++; $display("FAIL rstmid grant step %0d: got %h want %h", i, grant, e.grant); end
         if (grant_valid !== (e.grant != 8'h00)) begin n_err++; $display("FAIL rstmid valid step %0d: got %b", i, grant_valid); end
         if (timeout !== e.timeout) begin n_err++; $display("FAIL rstmid timeout step %0d: got %b want %b", i, timeout, e.timeout); end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      req           = 8'hFF;
      release_pulse = 1'b0;
      test_reset();
      mon_en = 1'b1;
      test_basic();
      test_fairness();
      test_timeout();
      test_coincide_and_hold();
      test_reset_mid_grant();
      mon_en = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
